// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Serial transmit stage for the UART line. Bytes arrive over a valid/ready handshake into a
//   one-entry holding register and are serialised as start(0), 8 data bits LSB first,
//   stop(1). The line idles high. With parity enabled, data bit 7 is replaced by a parity bit
//   computed over bits 6:0 so the receive side sees the same frame format.
//
// Ports
//   clkTx         in   1  transmit clock, rising edge
//   reset         in   1  asynchronous active-low reset
//   baudRate      in   3  rate select 0..4; codes 5..7 keep the previously selected rate
//   parity        in   2  0 none, 1 odd, 2 even, 3 none
//   txData        in   8  byte to send
//   txValid       in   1  txData valid
//   txReady       out  1  holding register empty; transfer on txValid & txReady
//   serialOutput  out  1  serial line, idle high
//   txBusy        out  1  frame in progress
//   txDone        out  1  one-cycle pulse in the last cycle of each stop bit

`timescale 1ns / 1ps

module uart_tx_framer #(
  parameter int unsigned CPB_1200   = 41667,
  parameter int unsigned CPB_2400   = 20833,
  parameter int unsigned CPB_4800   = 10417,
  parameter int unsigned CPB_9600   = 5208,
  parameter int unsigned CPB_115200 = 434
) (
  input  logic       clkTx,
  input  logic       reset,
  input  logic [2:0] baudRate,
  input  logic [1:0] parity,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       serialOutput,
  output logic       txBusy,
  output logic       txDone
);

  // Clocks-per-bit values narrowed to the 16-bit counter width.
  localparam logic [15:0] Cpb1200   = 16'(CPB_1200);
  localparam logic [15:0] Cpb2400   = 16'(CPB_2400);
  localparam logic [15:0] Cpb4800   = 16'(CPB_4800);
  localparam logic [15:0] Cpb9600   = 16'(CPB_9600);
  localparam logic [15:0] Cpb115200 = 16'(CPB_115200);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // Builds the on-wire byte. Odd/even naming follows the receive side's definition:
  // "odd" sends the XOR of bits 6:0, "even" sends its complement.
  function automatic logic [7:0] f_frame_byte(input logic [7:0] data, input logic [1:0] mode);
    logic [7:0] result;
    result = data;
    case (mode)
      2'd1:    result = {^data[6:0], data[6:0]};
      2'd2:    result = {~^data[6:0], data[6:0]};
      default: result = data;
    endcase
    return result;
  endfunction

  // ---------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------
  state_e      r_state;
  logic        r_serial;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_clk_count;
  logic [2:0]  r_bit_index;
  logic [7:0]  r_frame;
  logic [15:0] r_cpb;       // rate in force for the current frame
  logic [15:0] r_cpb_next;  // rate the next frame will pick up
  logic        r_hold_full;
  logic [7:0]  r_hold_data;

  logic [15:0] w_cpb_sel;
  logic        w_load;
  logic        w_drain;
  logic        w_bit_end;
  logic        w_stop_last_next;
  logic [7:0]  w_frame_byte;

  // ---------------------------------------------------------------------------------------
  // Rate selection: sampled every cycle, unknown codes hold the last valid selection.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    w_cpb_sel = r_cpb_next;
    case (baudRate)
      3'd0:    w_cpb_sel = Cpb1200;
      3'd1:    w_cpb_sel = Cpb2400;
      3'd2:    w_cpb_sel = Cpb4800;
      3'd3:    w_cpb_sel = Cpb9600;
      3'd4:    w_cpb_sel = Cpb115200;
      default: w_cpb_sel = r_cpb_next;
    endcase
  end

  always_ff @(posedge clkTx or negedge reset) begin
    if (!reset) begin
      r_cpb_next <= Cpb9600;
    end else begin
      r_cpb_next <= w_cpb_sel;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Bit timing
  // ---------------------------------------------------------------------------------------
  assign w_bit_end        = (r_clk_count == (r_cpb - 16'd1));
  // Counter will reach its last value on the next edge; used to register txDone so it lines
  // up with the final stop-bit cycle. CPB >= 2 keeps this well defined.
  assign w_stop_last_next = (r_clk_count == (r_cpb - 16'd2));

  // ---------------------------------------------------------------------------------------
  // Holding register
  // ---------------------------------------------------------------------------------------
  assign w_load       = txValid & ~r_hold_full;
  // A new frame starts (and the holding register empties) either from idle, or straight out
  // of the final stop-bit cycle for back-to-back frames.
  assign w_drain      = r_hold_full &
                        ((r_state == StIdle) || ((r_state == StStop) && w_bit_end));
  assign w_frame_byte = f_frame_byte(r_hold_data, parity);

  always_ff @(posedge clkTx or negedge reset) begin
    if (!reset) begin
      r_hold_full <= 1'b0;
      r_hold_data <= 8'h00;
    end else if (w_load) begin
      // Load wins over a same-cycle drain: the register stays full with the new byte.
      r_hold_full <= 1'b1;
      r_hold_data <= txData;
    end else if (w_drain) begin
      r_hold_full <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Framing FSM with registered line, busy and done outputs
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clkTx or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_serial    <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_clk_count <= 16'd0;
      r_bit_index <= 3'd0;
      r_frame     <= 8'h00;
      r_cpb       <= Cpb9600;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_serial    <= 1'b1;
          r_busy      <= 1'b0;
          r_clk_count <= 16'd0;
          r_bit_index <= 3'd0;
          if (r_hold_full) begin
            r_state  <= StStart;
            r_serial <= 1'b0;
            r_busy   <= 1'b1;
            r_frame  <= w_frame_byte;
            r_cpb    <= r_cpb_next;
          end
        end

        StStart: begin
          if (w_bit_end) begin
            r_state     <= StData;
            r_clk_count <= 16'd0;
            r_bit_index <= 3'd0;
            r_serial    <= r_frame[0];
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
          end
        end

        StData: begin
          if (w_bit_end) begin
            r_clk_count <= 16'd0;
            if (r_bit_index == 3'd7) begin
              r_state  <= StStop;
              r_serial <= 1'b1;
            end else begin
              r_bit_index <= r_bit_index + 3'd1;
              r_serial    <= r_frame[r_bit_index + 3'd1];
            end
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
          end
        end

        StStop: begin
          if (w_bit_end) begin
            r_clk_count <= 16'd0;
            r_bit_index <= 3'd0;
            if (r_hold_full) begin
              // Back-to-back: next start bit follows with no idle gap.
              r_state  <= StStart;
              r_serial <= 1'b0;
              r_busy   <= 1'b1;
              r_frame  <= w_frame_byte;
              r_cpb    <= r_cpb_next;
            end else begin
              r_state  <= StIdle;
              r_serial <= 1'b1;
              r_busy   <= 1'b0;
            end
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
            r_done      <= w_stop_last_next;
          end
        end

        default: begin
          r_state     <= StIdle;
          r_serial    <= 1'b1;
          r_busy      <= 1'b0;
          r_clk_count <= 16'd0;
          r_bit_index <= 3'd0;
        end
      endcase
    end
  end

  assign txReady      = ~r_hold_full;
  assign serialOutput = r_serial;
  assign txBusy       = r_busy;
  assign txDone       = r_done;

endmodule
